// File: rtl/poly_operand_driver.sv
// Go-button load initiator for the polynomial datapath: presents A, B, C, X with timed go
// presses, waits out the datapath's compute, then captures its result register.
module poly_operand_driver #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned COMPUTE_CYC = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPress,
        StCompute,
        StCapture
    } state_e;

    // Phase counters count down to zero, so each load is the phase length minus one.
    localparam logic [7:0] SetupLoad   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HoldLoad    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] ComputeLoad = 8'(COMPUTE_CYC - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] ops_q [4];
    logic [WIDTH-1:0] ops_d [4];
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             go_q, go_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ops_d      = ops_q;
        data_out_d = data_out_q;
        go_d       = go_q;
        busy_d     = busy_q;
        result_d   = result_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                go_d   = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    ops_d[0]   = a_in;
                    ops_d[1]   = b_in;
                    ops_d[2]   = c_in;
                    ops_d[3]   = x_in;
                    idx_d      = 2'd0;
                    data_out_d = a_in;
                    busy_d     = 1'b1;
                    cnt_d      = SetupLoad;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == 8'd0) begin
                    go_d    = 1'b1;
                    cnt_d   = HoldLoad;
                    state_d = StPress;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StPress: begin
                if (cnt_q == 8'd0) begin
                    go_d = 1'b0;
                    // Next operand goes out on the same edge go falls, keeping it stable
                    // for the whole following setup window.
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_q + 2'd1;
                        data_out_d = ops_q[idx_q + 2'd1];
                        cnt_d      = SetupLoad;
                        state_d    = StSetup;
                    end else begin
                        cnt_d   = ComputeLoad;
                        state_d = StCompute;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCompute: begin
                if (cnt_q == 8'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCapture: begin
                result_d = data_result;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
                go_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            cnt_q      <= 8'd0;
            ops_q[0]   <= '0;
            ops_q[1]   <= '0;
            ops_q[2]   <= '0;
            ops_q[3]   <= '0;
            data_out_q <= '0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            ops_q      <= ops_d;
            data_out_q <= data_out_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign go       = go_q;
    assign busy     = busy_q;
    assign result   = result_q;
    assign done     = done_q;

endmodule
